// File: rtl/zsram_pkg.sv
// Shared types and helpers for the zero-second RAM array.
// Holds the clear FSM encoding, read-hit constants and the address-width helper.
package zsram_pkg;

  typedef enum logic [0:0] {
    ZS_IDLE  = 1'b0,
    ZS_CLEAR = 1'b1
  } zsram_state_t;

  localparam logic ZS_READ_HIT  = 1'b1;
  localparam logic ZS_READ_MISS = 1'b0;

  // A one-word-deep or two-word array still needs a 1-bit address.
  function automatic int zsram_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/zsram_array_if.sv
// Write/read/clear port bundle of zsram_array; slave is the array, master is its user.
// No flow control: requests arriving while Busy is high are dropped, the master must retry.
interface zsram_array_if
  import zsram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = zsram_aw(DEPTH);

  logic             WriteEdge;
  logic [AW-1:0]    WriteAddr;
  logic [WIDTH-1:0] inputData;
  logic             ReadEdge;
  logic [AW-1:0]    ReadAddr;
  logic [WIDTH-1:0] outputData;
  logic             ReadValid;
  logic             ReadHit;
  logic             ClearStart;
  logic             Busy;

  modport master (
    output WriteEdge, WriteAddr, inputData, ReadEdge, ReadAddr, ClearStart,
    input  outputData, ReadValid, ReadHit, Busy
  );

  modport slave (
    input  WriteEdge, WriteAddr, inputData, ReadEdge, ReadAddr, ClearStart,
    output outputData, ReadValid, ReadHit, Busy
  );

endinterface

// File: rtl/zsram_clear_ctrl.sv
// Sequential clear engine: wipes one word per cycle, Busy high for exactly DEPTH cycles.
// ClearStart is ignored while a clear is already running; there is no restart.
module zsram_clear_ctrl
  import zsram_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = zsram_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          ClearStart,
  output logic          Busy,
  output logic [AW-1:0] ClearAddr,
  output logic          ClearWe
);

  localparam logic [0:0]    ST_IDLE  = ZS_IDLE;
  localparam logic [0:0]    ST_CLEAR = ZS_CLEAR;
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ClearStart) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state == ST_CLEAR);
  assign ClearWe   = Busy;
  assign ClearAddr = ptr;

endmodule

// File: rtl/zsram_array.sv
// DEPTH x WIDTH scratch RAM with write-first bypass, per-word valid bits and a hardware clear.
// Read latency 1 cycle; strobes during a clear or to out-of-range addresses are dropped.
module zsram_array
  import zsram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = zsram_aw(DEPTH)
) (
  input  logic          Crystal50Mhz,
  input  logic          ResetN,
  zsram_array_if.slave  bus
);

  localparam bit          POW2    = (DEPTH == (1 << AW));
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic             clrBusy;
  logic             clrWe;
  logic [AW-1:0]    clrAddr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] validBits;
  logic             wrAcc;
  logic             rdAcc;
  logic             bypass;

  function automatic logic inRange(input logic [AW-1:0] a);
    return POW2 ? 1'b1 : ({1'b0, a} < DEPTH_W);
  endfunction

  zsram_clear_ctrl #(.DEPTH(DEPTH)) uClear (
    .clk        (Crystal50Mhz),
    .rstN       (ResetN),
    .ClearStart (bus.ClearStart),
    .Busy       (clrBusy),
    .ClearAddr  (clrAddr),
    .ClearWe    (clrWe)
  );

  assign bus.Busy = clrBusy;
  assign wrAcc    = bus.WriteEdge && inRange(bus.WriteAddr) && !clrBusy;
  assign rdAcc    = bus.ReadEdge  && inRange(bus.ReadAddr)  && !clrBusy;
  assign bypass   = wrAcc && (bus.WriteAddr == bus.ReadAddr);

  // Storage carries no reset; the valid bits alone give unwritten words their zero value.
  always_ff @(posedge Crystal50Mhz) begin
    if (clrWe) begin
      mem[clrAddr] <= '0;
    end else if (wrAcc) begin
      mem[bus.WriteAddr] <= bus.inputData;
    end
  end

  always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
    if (!ResetN) begin
      validBits <= '0;
    end else if (clrWe) begin
      validBits[clrAddr] <= 1'b0;
    end else if (wrAcc) begin
      validBits[bus.WriteAddr] <= 1'b1;
    end
  end

  always_ff @(posedge Crystal50Mhz or negedge ResetN) begin
    if (!ResetN) begin
      bus.outputData <= '0;
      bus.ReadValid  <= 1'b0;
      bus.ReadHit    <= ZS_READ_MISS;
    end else begin
      bus.ReadValid <= rdAcc;
      if (rdAcc) begin
        if (bypass) begin
          bus.outputData <= bus.inputData;
          bus.ReadHit    <= ZS_READ_HIT;
        end else if (validBits[bus.ReadAddr]) begin
          bus.outputData <= mem[bus.ReadAddr];
          bus.ReadHit    <= ZS_READ_HIT;
        end else begin
          bus.outputData <= '0;
          bus.ReadHit    <= ZS_READ_MISS;
        end
      end else begin
        // Rejected or idle read: data holds, hit is forced low.
        bus.ReadHit <= ZS_READ_MISS;
      end
    end
  end

endmodule

// File: tb/tb_zsram_array.sv
// Drives a 16-deep and a 12-deep array with identical stimulus and checks both against a word-level model.
module tb_zsram_array;

  logic       clk;
  logic       rstN;
  logic       we, re, cs;
  logic [3:0] wa, ra;
  logic [7:0] wd;

  zsram_array_if #(.WIDTH(8), .DEPTH(16)) bus16 ();
  zsram_array_if #(.WIDTH(8), .DEPTH(12)) bus12 ();

  assign bus16.WriteEdge = we;  assign bus12.WriteEdge = we;
  assign bus16.WriteAddr = wa;  assign bus12.WriteAddr = wa;
  assign bus16.inputData = wd;  assign bus12.inputData = wd;
  assign bus16.ReadEdge  = re;  assign bus12.ReadEdge  = re;
  assign bus16.ReadAddr  = ra;  assign bus12.ReadAddr  = ra;
  assign bus16.ClearStart = cs; assign bus12.ClearStart = cs;

  zsram_array #(.WIDTH(8), .DEPTH(16)) dut16 (.Crystal50Mhz(clk), .ResetN(rstN), .bus(bus16.slave));
  zsram_array #(.WIDTH(8), .DEPTH(12)) dut12 (.Crystal50Mhz(clk), .ResetN(rstN), .bus(bus12.slave));

  logic [7:0] oDat [2];
  logic       oVal [2];
  logic       oHit [2];
  logic       oBusy[2];
  assign oDat[0] = bus16.outputData; assign oDat[1] = bus12.outputData;
  assign oVal[0] = bus16.ReadValid;  assign oVal[1] = bus12.ReadValid;
  assign oHit[0] = bus16.ReadHit;    assign oHit[1] = bus12.ReadHit;
  assign oBusy[0] = bus16.Busy;      assign oBusy[1] = bus12.Busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;
  bit chkEn   = 0;

  // Word-level model: contents, written flags and remaining busy cycles per instance.
  int   dep [2] = '{16, 12};
  int   mMem [2][16];
  bit   mVld [2][16];
  int   mBusy[2];
  bit   eVal [2];
  bit   eHit [2];
  int   eDat [2];

  function automatic void chk(string nm, int act, int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k] = 0; eVal[k] = 0; eHit[k] = 0; eDat[k] = 0;
      for (int i = 0; i < 16; i++) mVld[k][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit idle = (mBusy[k] == 0);
      bit wOk  = we && (int'(wa) < dep[k]) && idle;
      bit rOk  = re && (int'(ra) < dep[k]) && idle;
      eVal[k] = rOk;
      if (rOk) begin
        if (wOk && wa == ra)        begin eDat[k] = int'(wd);       eHit[k] = 1; end
        else if (mVld[k][int'(ra)]) begin eDat[k] = mMem[k][int'(ra)]; eHit[k] = 1; end
        else                        begin eDat[k] = 0;              eHit[k] = 0; end
      end else begin
        eHit[k] = 0;
      end
      if (wOk) begin
        mMem[k][int'(wa)] = int'(wd);
        mVld[k][int'(wa)] = 1;
      end
      // Nothing can observe the array mid-clear, so the model wipes it all at once.
      if (mBusy[k] > 0) mBusy[k]--;
      else if (cs) begin
        mBusy[k] = dep[k];
        for (int i = 0; i < 16; i++) mVld[k][i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ReadValid[d%0d]", dep[k]), int'(oVal[k]), int'(eVal[k]));
        chk($sformatf("ReadHit[d%0d]", dep[k]), int'(oHit[k]), int'(eHit[k]));
        chk($sformatf("outputData[d%0d]", dep[k]), int'(oDat[k]), eDat[k]);
        chk($sformatf("Busy[d%0d]", dep[k]), int'(oBusy[k]), int'(mBusy[k] > 0));
      end
    end
  end

  int b16, b12;

  task automatic cyc(bit iwe, int iwa, int iwd, bit ire, int ira, bit ics);
    we = iwe; wa = iwa[3:0]; wd = iwd[7:0];
    re = ire; ra = ira[3:0]; cs = ics;
    @(posedge clk);
    if (rstN) model_step();
    @(negedge clk);
    #1;
    we = 0; re = 0; cs = 0;
    if (oBusy[0]) b16++;
    if (oBusy[1]) b12++;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstN = 0; we = 0; re = 0; cs = 0; wa = 0; ra = 0; wd = 0;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    chk("reset_outputData", int'(bus16.outputData), 0);
    chk("reset_ReadValid", int'(bus16.ReadValid), 0);
    chk("reset_Busy", int'(bus12.Busy), 0);
    chkEn = 1;
    rstN = 1;
    idle(1);

    // Unwritten word reads as zero with a miss.
    cyc(0, 0, 0, 1, 3, 0);
    chk("rd3_valid", int'(bus16.ReadValid), 1);
    chk("rd3_hit", int'(bus16.ReadHit), 0);
    chk("rd3_data", int'(bus16.outputData), 8'h00);

    cyc(1, 5, 8'hA5, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0);
    chk("rd5_hit", int'(bus16.ReadHit), 1);
    chk("rd5_data", int'(bus12.outputData), 8'hA5);

    cyc(1, 7, 8'h3C, 1, 7, 0);
    chk("bypass7_data", int'(bus16.outputData), 8'h3C);
    chk("bypass7_hit", int'(bus16.ReadHit), 1);
    idle(1);
    chk("idle_hit_forced_low", int'(bus16.ReadHit), 0);
    chk("idle_data_holds", int'(bus16.outputData), 8'h3C);
    cyc(0, 0, 0, 1, 7, 0);
    chk("reread7_data", int'(bus16.outputData), 8'h3C);

    // Out-of-range traffic on the 12-deep array.
    cyc(1, 11, 8'h11, 0, 0, 0);
    cyc(1, 13, 8'h77, 0, 0, 0);
    cyc(0, 0, 0, 1, 13, 0);
    chk("d12_rd13_valid", int'(bus12.ReadValid), 0);
    chk("d16_rd13_data", int'(bus16.outputData), 8'h77);
    cyc(0, 0, 0, 1, 11, 0);
    chk("d12_rd11_data", int'(bus12.outputData), 8'h11);
    chk("d12_rd11_hit", int'(bus12.ReadHit), 1);

    // Fill, then clear with a same-cycle write that the clear must erase.
    for (int i = 0; i < 16; i++) cyc(1, i, i, 0, 0, 0);
    b16 = 0; b12 = 0;
    cyc(1, 1, 8'hEE, 1, 4, 1);
    chk("clr_same_cycle_read", int'(bus16.outputData), 8'h04);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) cyc(1, 2, 8'h99, 1, 2, 0);
      else idle(1);
      if (i == 2) chk("rd_during_busy", int'(bus16.ReadValid), 0);
    end
    chk("busy_cycles_d16", b16, 16);
    chk("busy_cycles_d12", b12, 12);
    cyc(0, 0, 0, 1, 2, 0);
    chk("post_clear_rd2_hit", int'(bus16.ReadHit), 0);
    chk("post_clear_rd2_data", int'(bus16.outputData), 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("post_clear_rd1_hit", int'(bus12.ReadHit), 0);

    // Reset in the fifth busy cycle, then a full clear from scratch.
    for (int i = 0; i < 16; i++) cyc(1, i, 8'h40 + i, 0, 0, 0);
    b16 = 0;
    cyc(0, 0, 0, 0, 0, 1);
    idle(4);
    chk("busy_before_reset", b16, 5);
    rstN = 0;
    model_reset();
    #1;
    chk("midclear_reset_busy16", int'(bus16.Busy), 0);
    chk("midclear_reset_busy12", int'(bus12.Busy), 0);
    @(posedge clk); @(negedge clk); #1;
    rstN = 1;
    cyc(0, 0, 0, 1, 4, 0);
    chk("after_reset_rd4_hit", int'(bus16.ReadHit), 0);
    chk("after_reset_rd4_data", int'(bus16.outputData), 0);
    b16 = 0; b12 = 0;
    cyc(0, 0, 0, 0, 0, 1);
    idle(20);
    chk("reclear_busy_d16", b16, 16);
    chk("reclear_busy_d12", b12, 12);

    for (int n = 0; n < 1500; n++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255),
          1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 39) == 0);
    end

    chkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
